// File: rtl/muldiv_unit_if.sv
// Core-side bus of the iterative multiply/divide unit: operation request,
// HI/LO write port, and the registered status/result outputs.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Define MULDIV_SIGNED_EN to make op[1] select signed mult/div.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic [WIDTH-1:0]   res_hi_d, res_lo_d;
  logic               is_div_q, dz_q, busy_q, done_q, divzero_q;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               start_dz_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s, diff_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s;

`ifdef MULDIV_SIGNED_EN
  logic               sgn_s, neg_lo_d, neg_hi_d, neg_lo_q, neg_hi_q;
  logic [2*WIDTH-1:0] prod_s;

  // Operand magnitudes and result sign flags computed at acceptance
  always_comb begin
    sgn_s    = bus.op[1];
    a_mag_s  = (sgn_s && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag_s  = (sgn_s && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_lo_d = sgn_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    neg_hi_d = sgn_s && bus.a[WIDTH-1];
  end
`else
  logic unused_op_s;
  assign unused_op_s = bus.op[1];

  // Unsigned build: operands pass straight through
  always_comb begin
    a_mag_s = bus.a;
    b_mag_s = bus.b;
  end
`endif

  assign start_dz_s = bus.op[0] && (bus.b == {WIDTH{1'b0}});

  // One iteration step of either algorithm plus final result shaping
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    // Remainder shifted left with the next dividend bit, then trial-subtracted
    rem_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, opnd_q};
    if (diff_s[WIDTH]) begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    acc_d = is_div_q ? div_next_s : mul_next_s;
`ifdef MULDIV_SIGNED_EN
    prod_s = neg_lo_q ? -acc_d : acc_d;
    if (is_div_q) begin
      res_lo_d = neg_lo_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
      res_hi_d = neg_hi_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    end else begin
      res_lo_d = prod_s[WIDTH-1:0];
      res_hi_d = prod_s[2*WIDTH-1:WIDTH];
    end
`else
    res_lo_d = acc_d[WIDTH-1:0];
    res_hi_d = acc_d[2*WIDTH-1:WIDTH];
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // A write coinciding with an accepted start is dropped
            acc_q     <= {{WIDTH{1'b0}}, (start_dz_s ? bus.a : a_mag_s)};
            opnd_q    <= b_mag_s;
            is_div_q  <= bus.op[0];
            dz_q      <= start_dz_s;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            divzero_q <= 1'b0;
            state_q   <= RUN;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
`endif
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            else           hi_q <= hi_q;
            if (bus.lo_we) lo_q <= bus.wdata;
            else           lo_q <= lo_q;
          end
        end
        RUN: begin
          if (dz_q) begin
            hi_q      <= acc_q[WIDTH-1:0];
            lo_q      <= {WIDTH{1'b1}};
            divzero_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              hi_q    <= res_hi_d;
              lo_q    <= res_lo_d;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              done_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divzero = divzero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit_if #(.WIDTH(32)) b32();
  muldiv_unit_if #(.WIDTH(8))  b8();

  muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
  muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    b32.start = 1'b1; b32.op = op; b32.a = a; b32.b = b;
    @(negedge clk);
    b32.start = 1'b0; b32.a = 32'hA5A5_A5A5; b32.b = 32'h0000_0000;
  endtask

  task automatic wait_done32(output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    while (b32.done !== 1'b1 && cyc < 200) begin
      if (b32.busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.divzero !== 1'b0) begin n_bad++; $display("FAIL reset_flags32 got busy=%b done=%b dz=%b want 0 0 0", b32.busy, b32.done, b32.divzero); end
    n_cmp++; if (b32.hi !== 32'h0 || b32.lo !== 32'h0) begin n_bad++; $display("FAIL reset_hilo32 got hi=%h lo=%h want 0 0", b32.hi, b32.lo); end
    n_cmp++; if (b8.busy !== 1'b0 || b8.hi !== 8'h0 || b8.lo !== 8'h0) begin n_bad++; $display("FAIL reset_w8 got busy=%b hi=%h lo=%h want 0 0 0", b8.busy, b8.hi, b8.lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_multu_full;
    int cyc, bc;
    start32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done32(cyc, bc);
    n_cmp++; if (cyc !== 32) begin n_bad++; $display("FAIL multu_latency got %0d want 32", cyc); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL multu_busy_cycles got %0d want 32", bc); end
    n_cmp++; if (b32.hi !== 32'hFFFF_FFFE || b32.lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_result got hi=%h lo=%h want fffffffe 00000001", b32.hi, b32.lo); end
    n_cmp++; if (b32.busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done got %b want 0", b32.busy); end
    @(negedge clk);
    n_cmp++; if (b32.done !== 1'b0) begin n_bad++; $display("FAIL multu_done_width got %b want 0", b32.done); end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    start32(2'b01, 32'd100, 32'd7);
    wait_done32(cyc, bc);
    n_cmp++; if (cyc !== 32) begin n_bad++; $display("FAIL divu_latency got %0d want 32", cyc); end
    n_cmp++; if (b32.lo !== 32'd14 || b32.hi !== 32'd2 || b32.divzero !== 1'b0) begin n_bad++; $display("FAIL divu_result got lo=%0d hi=%0d dz=%b want 14 2 0", b32.lo, b32.hi, b32.divzero); end
    // issue the divide-by-zero during the done cycle
    b32.start = 1'b1; b32.op = 2'b01; b32.a = 32'd5; b32.b = 32'd0;
    @(negedge clk);
    b32.start = 1'b0; b32.a = 32'h0; b32.b = 32'h1;
    n_cmp++; if (b32.busy !== 1'b1 || b32.done !== 1'b0) begin n_bad++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", b32.busy, b32.done); end
    wait_done32(cyc, bc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL dz_latency got %0d want 1", cyc); end
    n_cmp++; if (b32.hi !== 32'd5 || b32.lo !== 32'hFFFF_FFFF || b32.divzero !== 1'b1) begin n_bad++; $display("FAIL dz_result got hi=%h lo=%h dz=%b want 00000005 ffffffff 1", b32.hi, b32.lo, b32.divzero); end
    @(negedge clk);
    n_cmp++; if (b32.divzero !== 1'b1 || b32.done !== 1'b0) begin n_bad++; $display("FAIL dz_hold got dz=%b done=%b want 1 0", b32.divzero, b32.done); end
  endtask

  task automatic test_signed;
    int cyc, bc;
    logic [31:0] ehi, elo;
    start32(2'b10, 32'hFFFF_FFFD, 32'd5);
    wait_done32(cyc, bc);
`ifdef MULDIV_SIGNED_EN
    ehi = 32'hFFFF_FFFF; elo = 32'hFFFF_FFF1;
`else
    ehi = 32'h0000_0004; elo = 32'hFFFF_FFF1;
`endif
    n_cmp++; if (b32.hi !== ehi || b32.lo !== elo || b32.divzero !== 1'b0) begin n_bad++; $display("FAIL mult_signed got hi=%h lo=%h dz=%b want %h %h 0", b32.hi, b32.lo, b32.divzero, ehi, elo); end
    start32(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done32(cyc, bc);
`ifdef MULDIV_SIGNED_EN
    ehi = 32'hFFFF_FFFF; elo = 32'hFFFF_FFFD;
`else
    ehi = 32'h0000_0001; elo = 32'h7FFF_FFFC;
`endif
    n_cmp++; if (b32.hi !== ehi || b32.lo !== elo) begin n_bad++; $display("FAIL div_signed got hi=%h lo=%h want %h %h", b32.hi, b32.lo, ehi, elo); end
    start32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(cyc, bc);
`ifdef MULDIV_SIGNED_EN
    ehi = 32'h0000_0000; elo = 32'h8000_0000;
`else
    ehi = 32'h8000_0000; elo = 32'h0000_0000;
`endif
    n_cmp++; if (b32.hi !== ehi || b32.lo !== elo || b32.divzero !== 1'b0) begin n_bad++; $display("FAIL div_mostneg got hi=%h lo=%h dz=%b want %h %h 0", b32.hi, b32.lo, b32.divzero, ehi, elo); end
  endtask

  task automatic test_busy_inputs;
    int cyc, bc;
    start32(2'b00, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    b32.start = 1'b1; b32.op = 2'b01; b32.a = 32'd9; b32.b = 32'd0;
    b32.hi_we = 1'b1; b32.wdata = 32'h0000_DEAD;
    @(negedge clk);
    b32.start = 1'b0; b32.hi_we = 1'b0;
    wait_done32(cyc, bc);
    n_cmp++; if (cyc !== 26) begin n_bad++; $display("FAIL busy_in_latency got %0d want 26", cyc); end
    n_cmp++; if (b32.hi !== 32'd0 || b32.lo !== 32'd12 || b32.divzero !== 1'b0) begin n_bad++; $display("FAIL busy_in_result got hi=%h lo=%h dz=%b want 0 c 0", b32.hi, b32.lo, b32.divzero); end
    @(negedge clk);
    b32.lo_we = 1'b1; b32.wdata = 32'h0000_0055;
    @(negedge clk);
    b32.lo_we = 1'b0;
    n_cmp++; if (b32.lo !== 32'h55 || b32.hi !== 32'h0 || b32.busy !== 1'b0) begin n_bad++; $display("FAIL lo_write got lo=%h hi=%h busy=%b want 55 0 0", b32.lo, b32.hi, b32.busy); end
  endtask

  task automatic test_reset_mid;
    int cyc, bc;
    start32(2'b01, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.divzero !== 1'b0 || b32.hi !== 32'h0 || b32.lo !== 32'h0) begin n_bad++; $display("FAIL reset_mid got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", b32.busy, b32.done, b32.divzero, b32.hi, b32.lo); end
    @(negedge clk);
    reset = 1'b0;
    // a HI write alongside the accepted start must be dropped
    @(negedge clk);
    b32.start = 1'b1; b32.op = 2'b00; b32.a = 32'd6; b32.b = 32'd7;
    b32.hi_we = 1'b1; b32.wdata = 32'h0000_BEEF;
    @(negedge clk);
    b32.start = 1'b0; b32.hi_we = 1'b0;
    wait_done32(cyc, bc);
    n_cmp++; if (cyc !== 32 || b32.hi !== 32'h0 || b32.lo !== 32'd42) begin n_bad++; $display("FAIL restart got cyc=%0d hi=%h lo=%h want 32 0 2a", cyc, b32.hi, b32.lo); end
  endtask

  task automatic test_w8;
    int cyc;
    @(negedge clk);
    b8.start = 1'b1; b8.op = 2'b00; b8.a = 8'hFF; b8.b = 8'hFF;
    @(negedge clk);
    b8.start = 1'b0; b8.a = 8'h00; b8.b = 8'h00;
    cyc = 0;
    while (b8.done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL w8_mul_latency got %0d want 8", cyc); end
    n_cmp++; if (b8.hi !== 8'hFE || b8.lo !== 8'h01) begin n_bad++; $display("FAIL w8_multu got hi=%h lo=%h want fe 01", b8.hi, b8.lo); end
    @(negedge clk);
    b8.start = 1'b1; b8.op = 2'b01; b8.a = 8'h80; b8.b = 8'h03;
    @(negedge clk);
    b8.start = 1'b0;
    cyc = 0;
    while (b8.done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_cmp++; if (cyc !== 8 || b8.lo !== 8'h2A || b8.hi !== 8'h02) begin n_bad++; $display("FAIL w8_divu got cyc=%0d lo=%h hi=%h want 8 2a 02", cyc, b8.lo, b8.hi); end
  endtask

  initial begin
    b32.start = 1'b0; b32.op = 2'b00; b32.a = 32'h0; b32.b = 32'h0;
    b32.hi_we = 1'b0; b32.lo_we = 1'b0; b32.wdata = 32'h0;
    b8.start = 1'b0; b8.op = 2'b00; b8.a = 8'h0; b8.b = 8'h0;
    b8.hi_we = 1'b0; b8.lo_we = 1'b0; b8.wdata = 8'h0;
    test_reset();
    test_multu_full();
    test_back_to_back();
    test_signed();
    test_busy_inputs();
    test_reset_mid();
    test_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
